// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment patterns in {a,b,c,d,e,f,g} order (active-low),
// reader FSM states and the pattern-to-value decode used by the receive path.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [4:0] VAL_BLANK = 5'b11111;

  typedef enum logic {WAIT_STABLE, EMIT} state_e;

  typedef struct packed {
    logic [3:0] hex;
    logic       blank;  // value must read as all-ones
    logic       err;
  } seg_dec_t;

  function automatic seg_dec_t decode_seg(input logic [6:0] pat);
    seg_dec_t r;
    r = '{hex: 4'h0, blank: 1'b0, err: 1'b0};
    case (pat)
      SEG_0:     r.hex = 4'h0;
      SEG_1:     r.hex = 4'h1;
      SEG_2:     r.hex = 4'h2;
      SEG_3:     r.hex = 4'h3;
      SEG_4:     r.hex = 4'h4;
      SEG_5:     r.hex = 4'h5;
      SEG_6:     r.hex = 4'h6;
      SEG_7:     r.hex = 4'h7;
      SEG_8:     r.hex = 4'h8;
      SEG_9:     r.hex = 4'h9;
      SEG_A:     r.hex = 4'hA;
      SEG_B:     r.hex = 4'hB;
      SEG_C:     r.hex = 4'hC;
      SEG_D:     r.hex = 4'hD;
      SEG_E:     r.hex = 4'hE;
      SEG_F:     r.hex = 4'hF;
      SEG_BLANK: r.blank = 1'b1;
      default: begin
        r.blank = 1'b1;
        r.err   = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_reader_if.sv
// Valid/ready output stream of the 7-segment reader.
interface seven_seg_reader_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic [DATA_WIDTH:0] value_out;
  logic                err;
  logic                valid_out;
  logic                ready_in;

  modport master (output value_out, output err, output valid_out, input ready_in);
  modport slave  (input value_out, input err, input valid_out, output ready_in);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of asynchronous inputs; resets to all-ones.
module sync_2ff #(
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/seven_seg_reader.sv
// 7-segment receive path: synchronize, debounce, suppress repeats, decode and present the
// value on a valid/ready stream with a sticky overrun flag.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic clr_ovr,
  output logic overrun,
  seven_seg_reader_if.master out_if
);
  logic [6:0]       pat_s;
  logic [6:0]       pat_q, pat_d;
  logic [6:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [DATA_WIDTH:0] value_q, value_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             accept, pop, ovr_set;
  seg_dec_t         dec;

  sync_2ff #(.Width(7)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({a, b, c, d, e, f, g}),
    .q_o   (pat_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= SEG_BLANK;
      last_q  <= SEG_BLANK;
      cnt_q   <= '0;
      state_q <= WAIT_STABLE;
      value_q <= '1;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      value_q <= value_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    pat_d = pat_q;
    cnt_d = cnt_q;
    if (pat_s != pat_q) begin
      pat_d = pat_s;
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Accept on the edge where the counter reaches STABLE_CYCLES-1 (STABLE_CYCLES matching samples).
    accept = (pat_s == pat_q) && (cnt_q == CNT_W'(STABLE_CYCLES - 2));
  end

  assign dec = decode_seg(pat_q);
  assign pop = valid_q && out_if.ready_in;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    value_d = value_q;
    err_d   = err_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (pop) valid_d = 1'b0;
    case (state_q)
      WAIT_STABLE: begin
        if (accept && (pat_q != last_q)) state_d = EMIT;
      end
      EMIT: begin
        state_d = WAIT_STABLE;
        last_d  = pat_q;
        if (!valid_q || pop) begin
          value_d = dec.blank ? '1 : (DATA_WIDTH + 1)'(dec.hex);
          err_d   = dec.err;
          valid_d = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = WAIT_STABLE;
    endcase
    ovr_d = clr_ovr ? 1'b0 : (ovr_set | ovr_q);
  end

  assign out_if.value_out = value_q;
  assign out_if.err       = err_q;
  assign out_if.valid_out = valid_q;
  assign overrun          = ovr_q;
endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: latency, debounce, repeat suppression, overrun, reset.
module tb_seven_seg_reader;
  logic clk;
  logic rst_n;
  logic a, b, c, d, e, f, g;
  logic clr_ovr;
  logic overrun;
  int   n_checks = 0;
  int   n_pass   = 0;

  seven_seg_reader_if #(.DATA_WIDTH(4)) out_if ();

  seven_seg_reader #(
    .DATA_WIDTH    (4),
    .STABLE_CYCLES (8),
    .CNT_W         (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .e       (e),
    .f       (f),
    .g       (g),
    .clr_ovr (clr_ovr),
    .overrun (overrun),
    .out_if  (out_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_seg(input logic [6:0] p);
    {a, b, c, d, e, f, g} = p;
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (out_if.valid_out) cnt++;
    end
  endtask

  int nv;

  initial begin
    rst_n = 1'b0;
    clr_ovr = 1'b0;
    out_if.ready_in = 1'b1;
    set_seg(7'b0000110);
    step(2);
    check_eq("rst_value", 8'(out_if.value_out), 8'h1F);
    check_eq("rst_err", 8'(out_if.err), 8'h0);
    check_eq("rst_valid", 8'(out_if.valid_out), 8'h0);
    check_eq("rst_ovr", 8'(overrun), 8'h0);

    // 3 held through reset: reported 2 + 8 + 1 edges after release
    rst_n = 1'b1;
    step(10);
    check_eq("lat_not_early", 8'(out_if.valid_out), 8'h0);
    step(1);
    check_eq("lat_valid", 8'(out_if.valid_out), 8'h1);
    check_eq("lat_value3", 8'(out_if.value_out), 8'h03);
    check_eq("lat_err", 8'(out_if.err), 8'h0);
    step(1);
    check_eq("pop3", 8'(out_if.valid_out), 8'h0);

    // 4, then 3-cycle glitch to 8 and back: no further report
    set_seg(7'b1001100);
    step(11);
    check_eq("val4_valid", 8'(out_if.valid_out), 8'h1);
    check_eq("val4", 8'(out_if.value_out), 8'h04);
    step(1);
    set_seg(7'b0000000);
    step(3);
    set_seg(7'b1001100);
    count_valid(30, nv);
    check_eq("glitch_no_report", 8'(nv), 8'h0);
    check_eq("glitch_value", 8'(out_if.value_out), 8'h04);

    // illegal, then blank
    set_seg(7'b1111110);
    step(11);
    check_eq("ill_valid", 8'(out_if.valid_out), 8'h1);
    check_eq("ill_value", 8'(out_if.value_out), 8'h1F);
    check_eq("ill_err", 8'(out_if.err), 8'h1);
    step(1);
    set_seg(7'b1111111);
    step(11);
    check_eq("blank_valid", 8'(out_if.valid_out), 8'h1);
    check_eq("blank_value", 8'(out_if.value_out), 8'h1F);
    check_eq("blank_err", 8'(out_if.err), 8'h0);
    step(1);

    // stalled consumer: 2 held, 5 dropped, overrun
    out_if.ready_in = 1'b0;
    set_seg(7'b0010010);
    step(11);
    check_eq("stall_valid2", 8'(out_if.valid_out), 8'h1);
    check_eq("stall_value2", 8'(out_if.value_out), 8'h02);
    set_seg(7'b0100100);
    step(10);
    check_eq("ovr_not_yet", 8'(overrun), 8'h0);
    step(1);
    check_eq("ovr_set", 8'(overrun), 8'h1);
    check_eq("stall_hold2", 8'(out_if.value_out), 8'h02);
    check_eq("stall_hold_v", 8'(out_if.valid_out), 8'h1);
    out_if.ready_in = 1'b1;
    step(1);
    check_eq("pop2", 8'(out_if.valid_out), 8'h0);
    check_eq("ovr_sticky", 8'(overrun), 8'h1);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    check_eq("ovr_clr", 8'(overrun), 8'h0);
    count_valid(20, nv);
    check_eq("no_repeat5", 8'(nv), 8'h0);

    // pop and new EMIT on the same edge: 7 -> F without a valid gap
    out_if.ready_in = 1'b0;
    set_seg(7'b0001111);
    step(11);
    check_eq("b2b_value7", 8'(out_if.value_out), 8'h07);
    set_seg(7'b0111000);
    step(10);
    check_eq("b2b_hold7", 8'(out_if.value_out), 8'h07);
    check_eq("b2b_valid7", 8'(out_if.valid_out), 8'h1);
    out_if.ready_in = 1'b1;
    step(1);
    check_eq("b2b_validF", 8'(out_if.valid_out), 8'h1);
    check_eq("b2b_valueF", 8'(out_if.value_out), 8'h0F);
    check_eq("b2b_ovr", 8'(overrun), 8'h0);
    step(1);
    check_eq("b2b_popF", 8'(out_if.valid_out), 8'h0);

    // reset mid-count with valid_out=1 and overrun=1
    out_if.ready_in = 1'b0;
    set_seg(7'b0000100);
    step(11);
    check_eq("pre_rst_value9", 8'(out_if.value_out), 8'h09);
    set_seg(7'b0000001);
    step(11);
    check_eq("pre_rst_ovr", 8'(overrun), 8'h1);
    set_seg(7'b1001111);
    step(4);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 8'(out_if.valid_out), 8'h0);
    check_eq("mid_rst_value", 8'(out_if.value_out), 8'h1F);
    check_eq("mid_rst_err", 8'(out_if.err), 8'h0);
    check_eq("mid_rst_ovr", 8'(overrun), 8'h0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check_eq("rerep_not_early", 8'(out_if.valid_out), 8'h0);
    step(1);
    check_eq("rerep_valid", 8'(out_if.valid_out), 8'h1);
    check_eq("rerep_value1", 8'(out_if.value_out), 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
